// File: rtl/pe_pkg.sv
// Shared types and constants for the pe_mac_act processing element and its activation unit.
package pe_pkg;

  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_RELU = 2'd1,
    ACT_BIN  = 2'd2
  } act_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } pe_state_t;

  localparam logic [7:0] BIN_ONE = 8'hFF;

endpackage

// File: rtl/pe_act.sv
// Combinational activation applied to a finished tile sum: pass-through, ReLU or threshold binarize.
module pe_act
  import pe_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 8,
  parameter int SIGNED = 1
) (
  input  logic [ACC_W-1:0] i_sum,
  input  logic [1:0]       i_mode,
  input  logic [ACC_W-1:0] i_thresh,
  output logic [ACC_W-1:0] o_y
);

  // Binarize "high" is all-ones over the operand width, zero-extended to the result width.
  localparam logic [ACC_W-1:0] BIN_HI = ACC_W'({DATA_W{1'b1}});

  logic w_neg;
  logic w_ge;

  assign w_neg = (SIGNED != 0) && i_sum[ACC_W-1];
  assign w_ge  = (SIGNED != 0) ? ($signed(i_sum) >= $signed(i_thresh))
                               : (i_sum >= i_thresh);

  always_comb begin
    o_y = i_sum;
    case (i_mode)
      ACT_RELU: if (w_neg) o_y = '0;
      ACT_BIN:  o_y = w_ge ? BIN_HI : '0;
      default:  o_y = i_sum;
    endcase
  end

endmodule

// File: rtl/pe_mac_act.sv
// Systolic PE: forwards operands east/south, accumulates a tile of saturating products,
// activates the tile sum and presents it behind a valid/ready result register.
module pe_mac_act
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 10,
  parameter int SIGNED = 1
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [1:0]        i_act_mode,
  input  logic [ACC_W-1:0]  i_thresh,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic              o_valid,
  output logic [ACC_W-1:0]  o_y,
  output logic              o_y_valid,
  input  logic              i_y_ready,
  output logic              o_sat,
  output logic              o_ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W + 1 - PROD_W;

  // Returns {clamped, value}; the sum carries one guard bit above the accumulator width.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W:0] s);
    logic [ACC_W:0] r;
    r = {1'b0, s[ACC_W-1:0]};
    if (SIGNED != 0) begin
      if (s[ACC_W] != s[ACC_W-1])
        r = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    end else if (s[ACC_W]) begin
      r = {1'b1, {ACC_W{1'b1}}};
    end
    return r;
  endfunction

  pe_state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_a_p1, r_b_p1;
  logic              r_vld_p1;
  logic [ACC_W-1:0]  r_acc;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic [ACC_W-1:0]  r_y_p1;
  logic              r_y_vld_p1;
  logic              r_sat;
  logic              r_ovf;

  logic signed [DATA_W-1:0] w_a_s, w_b_s;
  logic signed [PROD_W-1:0] w_a_sx, w_b_sx, w_prod_s;
  logic [PROD_W-1:0]        w_a_zx, w_b_zx, w_prod_u, w_prod;
  logic                     w_prod_msb;
  logic [ACC_W:0]           w_prod_ext, w_acc_ext, w_sum_ext, w_sat_res;
  logic [ACC_W-1:0]         w_acc_opnd, w_sum, w_act_y;
  logic                     w_clamp;
  logic [LEN_W-1:0]         w_len_in;
  logic                     w_tile_done;
  logic                     w_load, w_drop;

  // ---- stage p0: product, sign/zero extension and saturating add ----
  assign w_a_s    = i_a;
  assign w_b_s    = i_b;
  assign w_a_sx   = PROD_W'(w_a_s);
  assign w_b_sx   = PROD_W'(w_b_s);
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_a_zx   = PROD_W'(i_a);
  assign w_b_zx   = PROD_W'(i_b);
  assign w_prod_u = w_a_zx * w_b_zx;
  assign w_prod   = (SIGNED != 0) ? $unsigned(w_prod_s) : w_prod_u;

  assign w_prod_msb = (SIGNED != 0) && w_prod[PROD_W-1];
  assign w_prod_ext = {{EXT_W{w_prod_msb}}, w_prod};
  // The first beat of a tile starts from zero regardless of any leftover accumulator content.
  assign w_acc_opnd = (r_state == ST_ACC) ? r_acc : '0;
  assign w_acc_ext  = {(SIGNED != 0) && w_acc_opnd[ACC_W-1], w_acc_opnd};
  assign w_sum_ext  = w_acc_ext + w_prod_ext;
  assign w_sat_res  = sat_add(w_sum_ext);
  assign w_clamp    = w_sat_res[ACC_W];
  assign w_sum      = w_sat_res[ACC_W-1:0];
  assign w_len_in   = (i_len == '0) ? LEN_W'(1) : i_len;

  pe_act #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .SIGNED (SIGNED)
  ) u_act (
    .i_sum    (w_sum),
    .i_mode   (i_act_mode),
    .i_thresh (i_thresh),
    .o_y      (w_act_y)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tile_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          if (w_len_in == LEN_W'(1)) w_tile_done = 1'b1;
          else                       w_state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        if (i_valid && (r_cnt == r_len - LEN_W'(1))) begin
          w_tile_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
      w_tile_done = 1'b0;
    end
  end

  // A finished tile is accepted unless the held result is still waiting for downstream.
  assign w_load = w_tile_done && (!r_y_vld_p1 || i_y_ready);
  assign w_drop = w_tile_done && r_y_vld_p1 && !i_y_ready;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // ---- stage p1: neighbour forwarding registers ----
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_a_p1   <= '0;
      r_b_p1   <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= i_valid;
      if (i_valid) begin
        r_a_p1 <= i_a;
        r_b_p1 <= i_b;
      end
    end
  end

  // ---- stage p1: accumulator, tile counter, result register and sticky flags ----
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_y_p1     <= '0;
      r_y_vld_p1 <= 1'b0;
      r_sat      <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (i_clear) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_y_p1     <= '0;
      r_y_vld_p1 <= 1'b0;
      r_sat      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (i_valid) begin
        if (w_clamp) r_sat <= 1'b1;
        if (w_tile_done) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
          r_acc <= w_sum;
          r_cnt <= LEN_W'(1);
          r_len <= w_len_in;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + LEN_W'(1);
        end
      end
      if (w_load) begin
        r_y_p1     <= w_act_y;
        r_y_vld_p1 <= 1'b1;
      end else if (r_y_vld_p1 && i_y_ready) begin
        r_y_vld_p1 <= 1'b0;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign o_a       = r_a_p1;
  assign o_b       = r_b_p1;
  assign o_valid   = r_vld_p1;
  assign o_y       = r_y_p1;
  assign o_y_valid = r_y_vld_p1;
  assign o_sat     = r_sat;
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_pe_mac_act.sv
// Scoreboard bench for pe_mac_act: default 32-bit instance plus a 16-bit instance for saturation.
module tb_pe_mac_act;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_valid = 1'b0;
  logic        v16 = 1'b0;
  logic [7:0]  i_a = '0;
  logic [7:0]  i_b = '0;
  logic [9:0]  i_len = '0;
  logic [1:0]  i_act_mode = '0;
  logic [31:0] i_thresh = '0;
  logic [15:0] thresh16 = '0;
  logic        i_y_ready = 1'b0;
  logic        ready16 = 1'b1;

  logic [7:0]  o_a, o_b, a16, b16;
  logic        o_valid, o_y_valid, o_sat, o_ovf;
  logic        vld16, y_vld16, sat16, ovf16;
  logic [31:0] o_y;
  logic [15:0] y16;

  int vectors = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  m_a, m_b;
  logic        m_vld;

  always #5 clk = ~clk;

  pe_mac_act dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid),
    .i_a(i_a), .i_b(i_b), .i_len(i_len), .i_act_mode(i_act_mode), .i_thresh(i_thresh),
    .o_a(o_a), .o_b(o_b), .o_valid(o_valid), .o_y(o_y), .o_y_valid(o_y_valid),
    .i_y_ready(i_y_ready), .o_sat(o_sat), .o_ovf(o_ovf)
  );

  pe_mac_act #(.ACC_W(16)) dut16 (
    .i_clk(clk), .i_arst_n(rst_n), .i_clear(i_clear), .i_valid(v16),
    .i_a(i_a), .i_b(i_b), .i_len(i_len), .i_act_mode(i_act_mode), .i_thresh(thresh16),
    .o_a(a16), .o_b(b16), .o_valid(vld16), .o_y(y16), .o_y_valid(y_vld16),
    .i_y_ready(ready16), .o_sat(sat16), .o_ovf(ovf16)
  );

  // Forwarding reference: one-cycle delayed operands that hold during bubbles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_vld <= 1'b0;
    end else begin
      m_vld <= i_valid;
      if (i_valid) begin
        m_a <= i_a; m_b <= i_b;
      end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (o_a !== m_a || o_b !== m_b || o_valid !== m_vld) begin
      fails++;
      $display("FAIL fwd: got a=%h b=%h v=%b, want a=%h b=%h v=%b", o_a, o_b, o_valid, m_a, m_b, m_vld);
    end
    if (rst_n && !i_clear && o_y_valid && i_y_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL result: got unexpected y=%h, want none", o_y);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (o_y !== e) begin
          fails++;
          $display("FAIL result: got y=%h, want %h", o_y, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a, input int b);
    i_valid = 1'b1;
    i_a = 8'(a);
    i_b = 8'(b);
    step(1);
    i_valid = 1'b0;
    i_a = 8'($urandom);
    i_b = 8'($urandom);
  endtask

  task automatic beat16(input int a, input int b);
    v16 = 1'b1;
    i_a = 8'(a);
    i_b = 8'(b);
    step(1);
    v16 = 1'b0;
  endtask

  task automatic clear_pulse();
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step(1);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s drain: got %0d results pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    i_valid = 1'b1; i_a = 8'h5A; i_b = 8'hA5;
    step(2);
    vectors++;
    if ({o_a, o_b, o_valid, o_y, o_y_valid, o_sat, o_ovf} !== '0) begin
      fails++;
      $display("FAIL reset outs: got a=%h b=%h v=%b y=%h yv=%b s=%b o=%b, want all 0",
               o_a, o_b, o_valid, o_y, o_y_valid, o_sat, o_ovf);
    end
    i_valid = 1'b0;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic();
    i_act_mode = 2'd0; i_len = 10'd3; i_y_ready = 1'b0;
    beat(2, 3);
    i_len = 10'd1;
    beat(4, 5);
    exp_q.push_back(32'd20);
    beat(-1, 6);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (o_y_valid !== 1'b1 || o_y !== 32'd20) begin
        fails++;
        $display("FAIL basic hold %0d: got yv=%b y=%h, want yv=1 y=00000014", k, o_y_valid, o_y);
      end
      step(1);
    end
    i_y_ready = 1'b1;
    drain("basic");
    vectors++;
    if (o_y_valid !== 1'b0 || o_sat !== 1'b0) begin
      fails++;
      $display("FAIL basic after xfer: got yv=%b sat=%b, want 0 0", o_y_valid, o_sat);
    end
  endtask

  task automatic test_relu();
    i_len = 10'd2; i_y_ready = 1'b1;
    i_act_mode = 2'd1;
    beat(-10, 3);
    exp_q.push_back(32'd0);
    beat(2, 2);
    drain("relu");
    i_act_mode = 2'd0;
    beat(-10, 3);
    exp_q.push_back(32'hFFFF_FFE6);
    beat(2, 2);
    drain("none_neg");
    i_act_mode = 2'd3;
    beat(-10, 3);
    exp_q.push_back(32'hFFFF_FFE6);
    beat(2, 2);
    drain("mode3");
  endtask

  task automatic test_bin();
    i_act_mode = 2'd2; i_thresh = 32'd100; i_len = 10'd0; i_y_ready = 1'b1;
    exp_q.push_back(32'h0000_00FF);
    beat(10, 10);
    exp_q.push_back(32'd0);
    beat(9, 11);
    i_thresh = 32'hFFFF_FFFB;
    exp_q.push_back(32'h0000_00FF);
    beat(2, 2);
    drain("bin");
    i_act_mode = 2'd0; i_thresh = '0;
  endtask

  task automatic test_sat();
    i_len = 10'd4; i_act_mode = 2'd0;
    clear_pulse();
    for (int k = 0; k < 4; k++) beat16(127, 127);
    vectors++;
    if (y16 !== 16'h7FFF || y_vld16 !== 1'b1 || sat16 !== 1'b1) begin
      fails++;
      $display("FAIL sat16: got y=%h yv=%b sat=%b, want y=7fff yv=1 sat=1", y16, y_vld16, sat16);
    end
    vectors++;
    if (o_sat !== 1'b0) begin
      fails++;
      $display("FAIL sat32 idle: got sat=%b, want 0", o_sat);
    end
  endtask

  task automatic test_ovf();
    i_len = 10'd1; i_act_mode = 2'd0; i_y_ready = 1'b0;
    exp_q.push_back(32'd6);
    beat(2, 3);
    beat(7, 1);
    step(2);
    vectors++;
    if (o_y !== 32'd6 || o_y_valid !== 1'b1 || o_ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf drop: got y=%h yv=%b ovf=%b, want y=6 yv=1 ovf=1", o_y, o_y_valid, o_ovf);
    end
    exp_q.push_back(32'd7);
    i_y_ready = 1'b1;
    beat(7, 1);
    vectors++;
    if (o_y !== 32'd7 || o_y_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovf same-edge: got y=%h yv=%b, want y=7 yv=1", o_y, o_y_valid);
    end
    drain("ovf");
    clear_pulse();
    vectors++;
    if (o_ovf !== 1'b0 || o_y_valid !== 1'b0 || o_y !== 32'd0) begin
      fails++;
      $display("FAIL clear flags: got ovf=%b yv=%b y=%h, want 0 0 0", o_ovf, o_y_valid, o_y);
    end
  endtask

  task automatic test_back_to_back();
    i_len = 10'd1; i_act_mode = 2'd0; i_y_ready = 1'b1;
    exp_q.push_back(32'd1);
    beat(1, 1);
    exp_q.push_back(32'd6);
    beat(2, 3);
    exp_q.push_back(32'hFFFF_FFEC);
    beat(-4, 5);
    drain("b2b");
  endtask

  task automatic test_midtile();
    i_act_mode = 2'd0; i_y_ready = 1'b1;
    i_len = 10'd4;
    beat(5, 5);
    beat(6, 6);
    clear_pulse();
    i_len = 10'd1;
    exp_q.push_back(32'd9);
    beat(3, 3);
    drain("mid_clear");
    i_len = 10'd4;
    beat(5, 5);
    beat(6, 6);
    rst_n = 1'b0;
    #2;
    vectors++;
    if ({o_a, o_b, o_valid, o_y_valid, o_y} !== '0) begin
      fails++;
      $display("FAIL mid reset: got a=%h b=%h v=%b yv=%b y=%h, want all 0", o_a, o_b, o_valid, o_y_valid, o_y);
    end
    step(1);
    rst_n = 1'b1;
    i_len = 10'd1;
    exp_q.push_back(32'd9);
    beat(3, 3);
    drain("mid_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_bin();
    test_sat();
    test_ovf();
    test_back_to_back();
    test_midtile();
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/pe_mac_act.md
Name: pe_mac_act

Overview:
- Parametrised next-generation systolic processing element (PE) for the image-binarization array.
- Streams operands through to its east and south neighbours, and accumulates a tile of i_len signed or unsigned products.
- When a tile ends, it applies a selectable activation (none / ReLU / threshold-binarize) and holds the result in an output register with a valid/ready handshake.
- Adds saturation and overrun detection.

Parameters:
- DATA_W, 8: operand width of i_a/i_b.
- ACC_W, 32: accumulator and result width; must be >= 2*DATA_W.
- LEN_W, 10: width of the tile-length input.
- SIGNED, 1: 1 = two's-complement operands and accumulator; 0 = unsigned.

Ports:
- i_clk  in  1  clock.
- i_arst_n  in  1  asynchronous, active-low reset.
- i_clear  in  1  synchronous clear of the accumulator, FSM, result and sticky flags.
- i_valid  in  1  operand beat valid.
- i_a  in  DATA_W  activation operand from the west.
- i_b  in  DATA_W  weight operand from the north.
- i_len  in  LEN_W  MAC beats per tile; sampled on the first beat of a tile.
- i_act_mode  in  2  0 NONE, 1 RELU, 2 BINARIZE, 3 treated as NONE.
- i_thresh  in  ACC_W  binarize threshold; interpreted with the same signedness as SIGNED.
- o_a  out  DATA_W  registered i_a, to the east neighbour.
- o_b  out  DATA_W  registered i_b, to the south neighbour.
- o_valid  out  1  registered i_valid, to the neighbours.
- o_y  out  ACC_W  activated result.
- o_y_valid  out  1  result available.
- i_y_ready  in  1  downstream accepts the result.
- o_sat  out  1  sticky; accumulator saturated during some tile.
- o_ovf  out  1  sticky; a result was dropped.

Behaviour:
- Reset (i_arst_n low, asynchronous): every output and all internal state go to 0; FSM goes to IDLE.
- Forwarding path:
  - o_valid <= i_valid every cycle.
  - o_a/o_b load i_a/i_b only when i_valid=1 and otherwise hold.
  - Latency 1 cycle, independent of FSM state and of i_clear.
- Product: full 2*DATA_W-bit product, sign- or zero-extended to ACC_W+1 bits before the add.
- Saturating add:
  - Signed: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Unsigned: clamp to 2^ACC_W-1.
  - Any clamp sets o_sat.
- FSM states IDLE and ACC:
  - IDLE: on an i_valid beat, latch len_q = max(i_len,1) and set acc = product.
    - If len_q == 1, the tile completes on this beat.
    - Otherwise set cnt = 1 and go to ACC.
  - ACC: on each i_valid beat, acc = sat(acc + product) and cnt increments. The beat on which cnt == len_q-1 completes the tile: go to IDLE, acc = 0.
  - Bubbles (i_valid=0) hold all state.
- Tile completion:
  - The final sum passes through the activation and is written to y_q on the same edge; o_y_valid rises the next cycle (1-cycle latency from the last beat).
  - NONE: y = sum.
  - RELU: y = 0 if SIGNED and sum is negative, else sum.
  - BINARIZE: y = zero-extended all-ones DATA_W (8'hFF by default) if sum >= i_thresh, else 0.
  - i_act_mode and i_thresh are sampled on the completing beat.
- Result handshake:
  - A transfer occurs on an edge where o_y_valid && i_y_ready; o_y_valid then clears unless a new result loads on the same edge.
  - While o_y_valid=1 and i_y_ready=0, o_y is held stable.
  - Tile completes while the held result is not being accepted: the new result is dropped, o_ovf is set, and the old result is kept.
  - Completion and acceptance on the same edge: the new result loads and o_y_valid stays 1.
- i_clear has priority over every beat, completion and handshake in the same cycle. It zeroes acc, cnt, y_q, o_y_valid, o_sat and o_ovf, and sets the FSM to IDLE.
- Reset asserted mid-tile discards the partial sum; no result is emitted.
- i_len changes during a tile are ignored.

Decomposition:
- Package pe_pkg holds:
  - act_mode_t enum (ACT_NONE, ACT_RELU, ACT_BIN).
  - pe_state_t enum (ST_IDLE, ST_ACC).
  - Constant BIN_ONE = 8'hFF.
- One combinational sub-module, pe_act, implements the activation (NONE/RELU/BINARIZE) with parameters ACC_W, DATA_W and SIGNED.
- FSM, saturating accumulator, handshake and forwarding registers stay in pe_mac_act.

Test Plan:
- Default parameters (SIGNED=1, ACT_NONE), i_len=3, beats (2,3),(4,5),(-1,6) -> o_y=20 one cycle after the third beat; o_y_valid held until i_y_ready.
- i_len=2, ACT_RELU, beats (-10,3),(2,2) -> o_y=0. Same beats with ACT_NONE -> o_y = -26 (0xFFFFFFE6).
- ACT_BIN, i_thresh=100, i_len=1, beat (10,10) -> o_y=0xFF. Beat (9,11) -> o_y=0.
- ACC_W=16, i_len=4, four beats (127,127) -> o_y=16'h7FFF, o_sat=1.
- i_y_ready=0, two consecutive 1-beat tiles giving 6 then 7 -> o_y stays 6, o_ovf=1. With i_y_ready=1 on the second completion edge -> o_y=7, o_y_valid stays 1.
- Mid-tile case:
  - Stimulus: i_len=4; i_clear (or i_arst_n low) after 2 beats, then a fresh 1-beat tile (3,3).
  - Response: o_y=9; no stale partial sum.
  - Throughout: o_a/o_b/o_valid track the inputs with 1-cycle lag and hold during bubbles.
